// File: rtl/uart_block_framer.sv
// Purpose: gathers UART bytes into BLOCK_BYTES-wide blocks and serializes result blocks back out to a UART transmitter.
// Latency: a received block appears on BLK_OUT one cycle after its last byte; a transmit byte is issued one cycle after the transmitter goes idle.
// Backpressure: a completed block is dropped (OVERRUN) while BLK_OUT is still unaccepted; BLK_IN is accepted only in IDLE.
//
// Ports:
//   CLK, RST_N                          clock, asynchronous active-low reset
//   RX_DATA, RX_READY                   received byte and its one-cycle strobe
//   BLK_OUT, BLK_OUT_VALID/READY        assembled block to the consumer (valid/ready)
//   BLK_IN, BLK_IN_VALID/READY          result block from the producer (valid/ready)
//   TX_DATA, TX_START, TX_BUSY          byte interface to the UART transmitter
//   OVERRUN                             sticky: a completed block was dropped
//   TIMEOUT_ERR                         one-cycle pulse: a partial block was discarded
module uart_block_framer #(
  parameter int          BLOCK_BYTES  = 8,
  parameter logic [23:0] IDLE_TIMEOUT = 24'd1000000,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_READY,
  output logic [8*BLOCK_BYTES-1:0] BLK_OUT,
  output logic                     BLK_OUT_VALID,
  input  logic                     BLK_OUT_READY,
  input  logic [8*BLOCK_BYTES-1:0] BLK_IN,
  input  logic                     BLK_IN_VALID,
  output logic                     BLK_IN_READY,
  output logic [7:0]               TX_DATA,
  output logic                     TX_START,
  input  logic                     TX_BUSY,
  output logic                     OVERRUN,
  output logic                     TIMEOUT_ERR
);

  localparam int          CW      = $clog2(BLOCK_BYTES);
  localparam int          BW      = 8 * BLOCK_BYTES;
  localparam logic [CW-1:0] LAST  = CW'(BLOCK_BYTES - 1);
  localparam logic [23:0] TO_LAST = IDLE_TIMEOUT - 24'd1;

  // Maps a byte sequence number to its byte lane in the block.
  function automatic logic [CW-1:0] lane(input logic [CW-1:0] idx);
    return MSB_FIRST ? (LAST - idx) : idx;
  endfunction

  // ------------------------------------------------------------------
  // Receive path
  // ------------------------------------------------------------------
  logic [CW-1:0] rx_cnt;
  logic [23:0]   idle_timer;
  logic [BW-1:0] shadow;
  logic [BW-1:0] asm_next;

  // Shadow contents with the current byte merged in, so the final byte
  // can go straight to BLK_OUT on the edge it arrives.
  always_comb begin
    asm_next = shadow;
    asm_next[int'(lane(rx_cnt))*8 +: 8] = RX_DATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_cnt        <= '0;
      idle_timer    <= '0;
      shadow        <= '0;
      BLK_OUT       <= '0;
      BLK_OUT_VALID <= 1'b0;
      OVERRUN       <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
    end else begin
      TIMEOUT_ERR <= 1'b0;

      if (BLK_OUT_VALID && BLK_OUT_READY)
        BLK_OUT_VALID <= 1'b0;

      // A byte always wins over an expiring timer in the same cycle.
      if (RX_READY) begin
        idle_timer <= '0;
        shadow     <= asm_next;
        if (rx_cnt == LAST) begin
          rx_cnt <= '0;
          // Output register is free, or is being emptied this very cycle.
          if (!BLK_OUT_VALID || BLK_OUT_READY) begin
            BLK_OUT       <= asm_next;
            BLK_OUT_VALID <= 1'b1;
          end else begin
            OVERRUN <= 1'b1;
          end
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt != '0) begin
        if (idle_timer == TO_LAST) begin
          rx_cnt      <= '0;
          idle_timer  <= '0;
          TIMEOUT_ERR <= 1'b1;
        end else begin
          idle_timer <= idle_timer + 24'd1;
        end
      end else begin
        idle_timer <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Transmit path
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, SEND, ARM, DRAIN} tx_state_t;

  tx_state_t     tx_state;
  logic [BW-1:0] tx_buf;
  logic [CW-1:0] tx_idx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state     <= IDLE;
      tx_buf       <= '0;
      tx_idx       <= '0;
      BLK_IN_READY <= 1'b0;
      TX_START     <= 1'b0;
      TX_DATA      <= '0;
    end else begin
      TX_START <= 1'b0;
      case (tx_state)
        IDLE: begin
          // READY is a register, so it comes up one edge after reset release.
          if (BLK_IN_READY && BLK_IN_VALID) begin
            tx_buf       <= BLK_IN;
            tx_idx       <= '0;
            BLK_IN_READY <= 1'b0;
            tx_state     <= SEND;
          end else begin
            BLK_IN_READY <= 1'b1;
          end
        end
        SEND: begin
          if (!TX_BUSY) begin
            TX_DATA  <= tx_buf[int'(lane(tx_idx))*8 +: 8];
            TX_START <= 1'b1;
            tx_state <= ARM;
          end
        end
        ARM: begin
          // Wait for the transmitter to acknowledge the start by going busy.
          if (TX_BUSY)
            tx_state <= DRAIN;
        end
        DRAIN: begin
          if (!TX_BUSY) begin
            if (tx_idx == LAST) begin
              BLK_IN_READY <= 1'b1;
              tx_state     <= IDLE;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_state <= SEND;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_block_framer.sv
// Purpose: directed self-checking bench for uart_block_framer (MSB-first and LSB-first instances).
// Latency: expected values are hand-computed constants checked one cycle after each stimulus edge.
// Backpressure: consumer ready is driven per scenario; a 10-cycle busy transmitter model answers TX_START.
module tb_uart_block_framer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  RX_DATA;
  logic        RX_READY;
  logic        BLK_OUT_READY;
  logic [63:0] BLK_IN;
  logic        BLK_IN_VALID;
  logic        TX_BUSY;

  logic [63:0] blk_out;
  logic        blk_out_valid;
  logic        blk_in_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        overrun;
  logic        timeout_err;

  // LSB-first instance shares the receive inputs; its transmit side is idle.
  logic [63:0] l_blk_in       = 64'h0;
  logic        l_blk_in_valid = 1'b0;
  logic        l_tx_busy      = 1'b0;
  logic [63:0] l_blk_out;
  logic        l_blk_out_valid;
  logic        l_blk_in_ready;
  logic [7:0]  l_tx_data;
  logic        l_tx_start;
  logic        l_overrun;
  logic        l_timeout_err;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int to_cnt = 0;
  int tx_cnt = 0;
  logic [7:0] tx_log [0:63];

  uart_block_framer #(.BLOCK_BYTES(8), .IDLE_TIMEOUT(24'd100), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
    .BLK_OUT(blk_out), .BLK_OUT_VALID(blk_out_valid), .BLK_OUT_READY(BLK_OUT_READY),
    .BLK_IN(BLK_IN), .BLK_IN_VALID(BLK_IN_VALID), .BLK_IN_READY(blk_in_ready),
    .TX_DATA(tx_data), .TX_START(tx_start), .TX_BUSY(TX_BUSY),
    .OVERRUN(overrun), .TIMEOUT_ERR(timeout_err)
  );

  uart_block_framer #(.BLOCK_BYTES(8), .IDLE_TIMEOUT(24'd100), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
    .BLK_OUT(l_blk_out), .BLK_OUT_VALID(l_blk_out_valid), .BLK_OUT_READY(BLK_OUT_READY),
    .BLK_IN(l_blk_in), .BLK_IN_VALID(l_blk_in_valid), .BLK_IN_READY(l_blk_in_ready),
    .TX_DATA(l_tx_data), .TX_START(l_tx_start), .TX_BUSY(l_tx_busy),
    .OVERRUN(l_overrun), .TIMEOUT_ERR(l_timeout_err)
  );

  initial forever #5 CLK = ~CLK;

  // Event monitors, sampled mid-cycle.
  initial forever begin
    @(negedge CLK);
    if (blk_out_valid) vld_cnt++;
    if (timeout_err) to_cnt++;
    if (tx_start) begin
      tx_log[tx_cnt % 64] = tx_data;
      tx_cnt++;
    end
  end

  // Transmitter model: busy for 10 cycles after each start.
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (tx_start) begin
        TX_BUSY = 1'b1;
        repeat (10) @(negedge CLK);
        TX_BUSY = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_READY = 1'b1;
    @(posedge CLK); #1;
    RX_READY = 1'b0;
  endtask

  // Sends n bytes start, start+1, ... with one idle cycle between them;
  // returns 1 time unit after the last byte's edge.
  task automatic send_seq(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(start + 8'(i));
      if (i < n - 1) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; RX_DATA = 8'h0; RX_READY = 1'b0; BLK_OUT_READY = 1'b0;
    BLK_IN = 64'h0; BLK_IN_VALID = 1'b0;
    #12;
    checks++; if (blk_out_valid !== 1'b0) begin errors++; $display("FAIL rst_blk_out_valid: got %b expected 0", blk_out_valid); end
    checks++; if (blk_out !== 64'h0) begin errors++; $display("FAIL rst_blk_out: got %h expected 0", blk_out); end
    checks++; if (blk_in_ready !== 1'b0) begin errors++; $display("FAIL rst_blk_in_ready: got %b expected 0", blk_in_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL rst_tx_data: got %h expected 0", tx_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    #8; RST_N = 1'b1;
    #1;
    checks++; if (blk_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_before_edge: got %b expected 0", blk_in_ready); end
    @(posedge CLK); #1;
    checks++; if (blk_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_edge: got %b expected 1", blk_in_ready); end
  endtask

  task automatic test_rx_basic;
    BLK_OUT_READY = 1'b1;
    vld_cnt = 0;
    send_seq(8'h30, 8);
    checks++; if (blk_out_valid !== 1'b1) begin errors++; $display("FAIL rx_valid: got %b expected 1", blk_out_valid); end
    checks++; if (blk_out !== 64'h3031323334353637) begin errors++; $display("FAIL rx_msb_block: got %h expected 3031323334353637", blk_out); end
    checks++; if (l_blk_out !== 64'h3736353433323130) begin errors++; $display("FAIL rx_lsb_block: got %h expected 3736353433323130", l_blk_out); end
    repeat (3) @(posedge CLK); #1;
    checks++; if (blk_out_valid !== 1'b0) begin errors++; $display("FAIL rx_valid_fall: got %b expected 0", blk_out_valid); end
    checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL rx_valid_cycles: got %0d expected 1", vld_cnt); end
  endtask

  task automatic test_collision;
    BLK_OUT_READY = 1'b0;
    send_seq(8'h60, 8);
    @(posedge CLK); #1;
    checks++; if (blk_out !== 64'h6061626364656667) begin errors++; $display("FAIL col_first_block: got %h expected 6061626364656667", blk_out); end
    send_seq(8'h70, 7);
    @(posedge CLK); #1;
    BLK_OUT_READY = 1'b1;
    send_byte(8'h77);
    checks++; if (blk_out_valid !== 1'b1) begin errors++; $display("FAIL col_valid_kept: got %b expected 1", blk_out_valid); end
    checks++; if (blk_out !== 64'h7071727374757677) begin errors++; $display("FAIL col_second_block: got %h expected 7071727374757677", blk_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL col_no_overrun: got %b expected 0", overrun); end
    @(posedge CLK); #1;
    checks++; if (blk_out_valid !== 1'b0) begin errors++; $display("FAIL col_valid_fall: got %b expected 0", blk_out_valid); end
  endtask

  task automatic test_overrun;
    BLK_OUT_READY = 1'b0;
    send_seq(8'h40, 8);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear_first: got %b expected 0", overrun); end
    @(posedge CLK); #1;
    send_seq(8'h48, 8);
    checks++; if (blk_out !== 64'h4041424344454647) begin errors++; $display("FAIL ovr_block_kept: got %h expected 4041424344454647", blk_out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    checks++; if (blk_out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", blk_out_valid); end
    BLK_OUT_READY = 1'b1;
    @(posedge CLK); #1;
    checks++; if (blk_out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", blk_out_valid); end
    send_seq(8'h50, 8);
    checks++; if (blk_out !== 64'h5051525354555657) begin errors++; $display("FAIL ovr_counter_zero: got %h expected 5051525354555657", blk_out); end
    @(posedge CLK); #1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_timeout;
    BLK_OUT_READY = 1'b1;
    to_cnt = 0;
    send_seq(8'h11, 3);
    repeat (90) @(posedge CLK); #1;
    checks++; if (to_cnt !== 0) begin errors++; $display("FAIL to_early: got %0d expected 0", to_cnt); end
    repeat (20) @(posedge CLK); #1;
    checks++; if (to_cnt !== 1) begin errors++; $display("FAIL to_pulse_once: got %0d expected 1", to_cnt); end
    send_seq(8'h80, 8);
    checks++; if (blk_out !== 64'h8081828384858687) begin errors++; $display("FAIL to_clean_block: got %h expected 8081828384858687", blk_out); end
    @(posedge CLK); #1;
    // A byte landing exactly in the expiry cycle keeps the partial block.
    to_cnt = 0;
    send_seq(8'h91, 3);
    repeat (99) @(posedge CLK);
    #1;
    send_seq(8'h94, 5);
    checks++; if (blk_out !== 64'h9192939495969798) begin errors++; $display("FAIL to_priority_block: got %h expected 9192939495969798", blk_out); end
    checks++; if (l_blk_out !== 64'h9897969594939291) begin errors++; $display("FAIL to_priority_lsb: got %h expected 9897969594939291", l_blk_out); end
    checks++; if (to_cnt !== 0) begin errors++; $display("FAIL to_priority_none: got %0d expected 0", to_cnt); end
    @(posedge CLK); #1;
  endtask

  task automatic test_tx;
    int base;
    logic [63:0] e;
    e = 64'h0123456789ABCDEF;
    base = tx_cnt;
    checks++; if (blk_in_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_idle: got %b expected 1", blk_in_ready); end
    BLK_IN = e; BLK_IN_VALID = 1'b1;
    @(posedge CLK); #1;
    BLK_IN_VALID = 1'b0;
    checks++; if (blk_in_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_busy: got %b expected 0", blk_in_ready); end
    for (int i = 0; i < 400 && tx_cnt < base + 8; i++) @(posedge CLK);
    for (int i = 0; i < 50 && blk_in_ready !== 1'b1; i++) begin @(posedge CLK); #1; end
    repeat (30) @(posedge CLK); #1;
    checks++; if (tx_cnt - base !== 8) begin errors++; $display("FAIL tx_start_count: got %0d expected 8", tx_cnt - base); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tx_log[(base + k) % 64] !== e[63-8*k -: 8]) begin
        errors++; $display("FAIL tx_byte_%0d: got %h expected %h", k, tx_log[(base + k) % 64], e[63-8*k -: 8]);
      end
    end
    checks++; if (blk_in_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_return: got %b expected 1", blk_in_ready); end
    checks++; if (tx_data !== 8'hEF) begin errors++; $display("FAIL tx_data_hold: got %h expected ef", tx_data); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [127:0] e;
    e = 128'h1122334455667788_99AABBCCDDEEFF00;
    base = tx_cnt;
    BLK_OUT_READY = 1'b1;
    fork
      begin
        BLK_IN = e[127:64]; BLK_IN_VALID = 1'b1;
        @(posedge CLK); #1;
        BLK_IN = e[63:0];
        for (int i = 0; i < 400 && blk_in_ready !== 1'b1; i++) begin @(posedge CLK); #1; end
        @(posedge CLK); #1;
        BLK_IN_VALID = 1'b0;
      end
      begin
        send_seq(8'hC0, 8);
        checks++; if (blk_out !== 64'hC0C1C2C3C4C5C6C7) begin errors++; $display("FAIL b2b_rx_block: got %h expected c0c1c2c3c4c5c6c7", blk_out); end
      end
    join
    for (int i = 0; i < 600 && tx_cnt < base + 16; i++) @(posedge CLK);
    repeat (30) @(posedge CLK); #1;
    checks++; if (tx_cnt - base !== 16) begin errors++; $display("FAIL b2b_start_count: got %0d expected 16", tx_cnt - base); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (tx_log[(base + k) % 64] !== e[127-8*k -: 8]) begin
        errors++; $display("FAIL b2b_byte_%0d: got %h expected %h", k, tx_log[(base + k) % 64], e[127-8*k -: 8]);
      end
    end
    checks++; if (blk_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_return: got %b expected 1", blk_in_ready); end
  endtask

  task automatic test_reset_mid_tx;
    int base;
    BLK_OUT_READY = 1'b0;
    send_seq(8'hE0, 8);
    @(posedge CLK); #1;
    base = tx_cnt;
    BLK_IN = 64'h0123456789ABCDEF; BLK_IN_VALID = 1'b1;
    @(posedge CLK); #1;
    BLK_IN_VALID = 1'b0;
    for (int i = 0; i < 400 && tx_cnt < base + 4; i++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    #3;
    checks++; if (tx_log[(base + 3) % 64] !== 8'h67) begin errors++; $display("FAIL mid_fourth_byte: got %h expected 67", tx_log[(base + 3) % 64]); end
    RST_N = 1'b0;
    #1;
    checks++; if (blk_out_valid !== 1'b0) begin errors++; $display("FAIL mid_blk_out_valid: got %b expected 0", blk_out_valid); end
    checks++; if (blk_out !== 64'h0) begin errors++; $display("FAIL mid_blk_out: got %h expected 0", blk_out); end
    checks++; if (blk_in_ready !== 1'b0) begin errors++; $display("FAIL mid_blk_in_ready: got %b expected 0", blk_in_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL mid_tx_data: got %h expected 0", tx_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b expected 0", overrun); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_timeout_err: got %b expected 0", timeout_err); end
    repeat (2) @(posedge CLK);
    #2; RST_N = 1'b1;
    #1;
    checks++; if (blk_in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_before_edge: got %b expected 0", blk_in_ready); end
    @(posedge CLK); #1;
    checks++; if (blk_in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after_edge: got %b expected 1", blk_in_ready); end
    base = tx_cnt;
    repeat (60) @(posedge CLK); #1;
    checks++; if (tx_cnt !== base) begin errors++; $display("FAIL mid_no_tx_start: got %0d expected %0d", tx_cnt, base); end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_collision();
    test_overrun();
    test_timeout();
    test_tx();
    test_back_to_back();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
